// File: rtl/empire_core_pipe.sv
// 3-stage valid/ready pipelined square/XOR/multiply core with a completed-transfer counter.
// Define EMPIRE_CORE_PIPE_AUX_EN to add the aux port carrying a*a + a + c*c.
module empire_core_pipe #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
`ifdef EMPIRE_CORE_PIPE_AUX_EN
    output logic [WIDTH-1:0] aux,
`endif
    output logic [CNT_W-1:0] done_count
);

    logic             advance;
    logic             v1_q, v2_q, v3_q;
    logic             v1_d, v2_d, v3_d;
    logic [WIDTH-1:0] a1_q, b1_q, c1_q, sq1_q, x01_q;
    logic             sel1_q;
    logic [WIDTH-1:0] sq_d, x0_d;
    logic [WIDTH-1:0] m5_q, w6_q, m5_d, w6_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Global stall: the whole pipe freezes whenever the output is held.
    assign advance  = !v3_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        v1_d = v1_q;
        v2_d = v2_q;
        v3_d = v3_q;
        if (advance) begin
            v1_d = in_valid;
            v2_d = v1_q;
            v3_d = v2_q;
        end
    end

    always_comb begin
        sq_d = in_a * in_a;
        x0_d = in_c ^ in_b;
        m5_d = sel1_q ? a1_q : sq1_q;
        w6_d = (sel1_q ? b1_q : x01_q) ^ (sel1_q ? sq1_q : c1_q);
        res_d = m5_q * w6_q;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (v3_q && out_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            res_q <= '0;
            cnt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            cnt_q <= cnt_d;
            // Only valid data enters stage 3, so result reads 0 until the first real result.
            if (advance && v2_q) begin
                res_q <= res_d;
            end
        end
    end

    // Stage 1/2 data carry no reset; their contents are qualified by the valids.
    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            a1_q   <= in_a;
            b1_q   <= in_b;
            c1_q   <= in_c;
            sel1_q <= sel;
            sq1_q  <= sq_d;
            x01_q  <= x0_d;
        end
        if (advance && v1_q) begin
            m5_q <= m5_d;
            w6_q <= w6_d;
        end
    end

`ifdef EMPIRE_CORE_PIPE_AUX_EN
    logic [WIDTH-1:0] p1_q, cc1_q, s2_q, aux_q;
    logic [WIDTH-1:0] p_d, cc_d, s_d;

    always_comb begin
        p_d  = in_a * in_a + in_a;
        cc_d = in_c * in_c;
        s_d  = p1_q + cc1_q;
    end

    always_ff @(posedge clk) begin
        if (advance && in_valid) begin
            p1_q  <= p_d;
            cc1_q <= cc_d;
        end
        if (advance && v1_q) begin
            s2_q <= s_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aux_q <= '0;
        end else if (advance && v2_q) begin
            aux_q <= s2_q;
        end
    end

    assign aux = aux_q;
`endif

    assign out_valid  = v3_q;
    assign result     = res_q;
    assign done_count = cnt_q;

endmodule

// File: tb/tb_empire_core_pipe.sv
// Directed self-checking bench for empire_core_pipe: latency, modes, truncation, stalls,
// mid-flight reset and counter wrap (second instance with CNT_W=4).
module tb_empire_core_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sel, out_valid, out_ready;
    logic [63:0] in_a, in_b, in_c, result;
    logic [31:0] done_count;
    logic        w_in_valid, w_in_ready, w_sel, w_out_valid, w_out_ready;
    logic [63:0] w_in_a, w_in_b, w_in_c, w_result;
    logic [3:0]  w_done;
`ifdef EMPIRE_CORE_PIPE_AUX_EN
    logic [63:0] aux, w_aux;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    empire_core_pipe #(.WIDTH(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef EMPIRE_CORE_PIPE_AUX_EN
        .aux(aux),
`endif
        .done_count(done_count)
    );

    empire_core_pipe #(.WIDTH(64), .CNT_W(4)) u_wrap (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_a(w_in_a), .in_b(w_in_b), .in_c(w_in_c), .sel(w_sel),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .result(w_result),
`ifdef EMPIRE_CORE_PIPE_AUX_EN
        .aux(w_aux),
`endif
        .done_count(w_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        w_in_valid = 1'b0;
        w_out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One accept in cycle N; out_valid must be high in cycle N+3 only.
    task automatic run_single(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic [63:0] c, input logic s, input logic [63:0] er,
                              input logic [63:0] ea, input logic [63:0] edone);
        in_a = a; in_b = b; in_c = c; sel = s;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid_n1"}, out_valid, 0);
        tick();
        check({tag, "_valid_n2"}, out_valid, 0);
        tick();
        check({tag, "_valid_n3"}, out_valid, 1);
        check({tag, "_result"}, result, er);
`ifdef EMPIRE_CORE_PIPE_AUX_EN
        check({tag, "_aux"}, aux, ea);
`endif
        $display("single %s: result=%0d", tag, result);
        tick();
        check({tag, "_valid_n4"}, out_valid, 0);
        check({tag, "_done"}, done_count, edone);
    endtask

    logic [63:0] sa [8] = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
    logic [63:0] sb [8] = '{64'd2, 64'd3, 64'd1, 64'd5, 64'd2, 64'd1, 64'd3, 64'd0};
    logic        ss [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [63:0] sr [8] = '{64'd2, 64'd14, 64'd9, 64'd84, 64'd50, 64'd222, 64'd147, 64'd512};
    logic [63:0] sx [8] = '{64'd3, 64'd7, 64'd13, 64'd21, 64'd31, 64'd43, 64'd57, 64'd73};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tx, rx, sent, got;
        logic have_hold;
        logic [63:0] hold;
        in_a = '0; in_b = '0; in_c = '0; sel = 1'b0;
        w_in_a = '0; w_in_b = '0; w_in_c = '0; w_sel = 1'b0;

        reset_dut();
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_done", done_count, 0);
        check("rst_in_ready", in_ready, 1);
`ifdef EMPIRE_CORE_PIPE_AUX_EN
        check("rst_aux", aux, 0);
`endif

        run_single("sq_mul", 64'd3, 64'd5, 64'd7, 1'b0, 64'd45, 64'd61, 64'd1);
        run_single("xor_mul", 64'd3, 64'd5, 64'd7, 1'b1, 64'd36, 64'd61, 64'd2);
        run_single("trunc", 64'h1_0000_0000, 64'd1, 64'd0, 1'b0, 64'd0, 64'h1_0000_0000, 64'd3);

        // Eight back-to-back sets with the consumer stalled in cycles 4-6.
        reset_dut();
        tx = 0; rx = 0; have_hold = 1'b0; hold = '0;
        for (int k = 0; k < 40 && rx < 8; k++) begin
            out_ready = !(k >= 4 && k <= 6);
            in_valid = (tx < 8);
            if (tx < 8) begin
                in_a = sa[tx]; in_b = sb[tx]; in_c = 64'd1; sel = ss[tx];
            end
            #1;
            check("stream_in_ready", in_ready, !(out_valid && !out_ready));
            if (k >= 4 && k <= 6) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
            end
            if (have_hold) begin
                check("stall_hold", result, hold);
            end
            have_hold = out_valid && !out_ready;
            hold = result;
            if (out_valid && out_ready) begin
                check("stream_result", result, sr[rx]);
`ifdef EMPIRE_CORE_PIPE_AUX_EN
                check("stream_aux", aux, sx[rx]);
`endif
                $display("stream out %0d: result=%0d", rx, result);
                rx++;
            end
            if (in_valid && in_ready) tx++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stream_count", rx, 8);
        check("stream_done", done_count, 8);

        // Three items in flight, output stalled, then reset.
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_a = 64'd9 + k; in_b = 64'd1; in_c = 64'd2; sel = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        check("flight_out_valid", out_valid, 1);
        check("flight_in_ready", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("mid-flight reset: out_valid=%0d done=%0d", out_valid, done_count);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_done", done_count, 0);
        check("midrst_result", result, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("midrst_drained", out_valid, 0);
        end

        // 17 transfers through a 4-bit counter.
        sent = 0; got = 0;
        w_out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 17; cyc++) begin
            w_in_valid = (sent < 17);
            w_in_a = 64'(sent + 1); w_in_b = 64'd1; w_in_c = 64'd0; w_sel = 1'b0;
            #1;
            if (w_out_valid) got++;
            if (w_in_valid && w_in_ready) sent++;
            @(posedge clk);
            #1;
            if (w_out_valid || got > 0) begin
                if (got == 15) check("wrap_at15", w_done, 15);
                if (got == 16) begin
                    check("wrap_to0", w_done, 0);
                    $display("wrap: done_count=%0d after 16 transfers", w_done);
                end
            end
        end
        w_in_valid = 1'b0;
        check("wrap_count", got, 17);
        check("wrap_final", w_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
